// File: rtl/fir_mac_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR MAC scheduler.
package fir_mac_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t OUT   = 2'd3;

    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w - 1 + $clog2(taps);
    endfunction

    // The multiplier only has a (w-1)-bit magnitude path, so the most negative code is pulled in by one.
    function automatic logic signed [63:0] sat_operand(input logic signed [63:0] v, input int w);
        logic signed [63:0] most_neg;
        most_neg = -(64'sd1 <<< (w - 1));
        return (v == most_neg) ? v + 64'sd1 : v;
    endfunction

    function automatic logic signed [63:0] sm_to_tc(input logic sign, input logic [63:0] mag);
        return sign ? -$signed(mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Sample delay line and coefficient bank with an indexed read port for the tap issuer.
module fir_tap_store
    import fir_mac_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int TAPS = 8,
    localparam int AW = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [DATA_W-1:0] coef_data,
    input  logic                     busy,
    input  logic [AW-1:0]            rd_idx,
    output logic signed [DATA_W-1:0] x_rd,
    output logic signed [DATA_W-1:0] h_rd
);

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [DATA_W-1:0] h [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (shift_en) begin
            x[0] <= s_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        end
    end

    // Writes while a sample is in progress are dropped so a running sum never sees mixed coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) h[i] <= '0;
        end else if (coef_we && !busy && (int'(coef_addr) < TAPS)) begin
            h[coef_addr] <= coef_data;
        end
    end

    assign x_rd = x[rd_idx];
    assign h_rd = h[rd_idx];

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller issuing one tap per cycle to a shared sign-magnitude multiplier and accumulating the products.
module fir_mac_scheduler
    import fir_mac_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int TAPS = 8,
    parameter int MUL_LATENCY = 2,
    localparam int ACC_W = acc_width(DATA_W, TAPS),
    localparam int AW = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [DATA_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] mul_a,
    output logic signed [DATA_W-1:0] mul_b,
    input  logic [2*DATA_W-2:0]      mul_p,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [ACC_W-1:0]  m_data,
    output logic                     busy
);

    localparam int PW = 2 * DATA_W - 1;

    state_t                   state;
    logic [AW-1:0]            k;
    logic [MUL_LATENCY-1:0]   vld_p;
    logic [MUL_LATENCY-1:0]   vld_shift;
    logic [MUL_LATENCY-1:0]   vld_next;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  prod_tc;
    logic signed [DATA_W-1:0] x_rd;
    logic signed [DATA_W-1:0] h_rd;
    logic                     accept;
    logic                     issue;

    assign accept  = (state == IDLE) && s_valid;
    assign issue   = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign s_ready = (state == IDLE);

    fir_tap_store #(
        .DATA_W(DATA_W),
        .TAPS  (TAPS)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .s_data   (s_data),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .busy     (busy),
        .rd_idx   (k),
        .x_rd     (x_rd),
        .h_rd     (h_rd)
    );

    // Stage boundary: the valid bit rides alongside each tap through the external multiplier.
    assign vld_shift = vld_p << 1;

    always_comb begin
        vld_next    = vld_shift;
        vld_next[0] = issue;
    end

    assign prod_tc = ACC_W'(sm_to_tc(mul_p[PW-1], 64'(mul_p[PW-2:0])));
    assign acc_sum = vld_p[MUL_LATENCY-1] ? acc + prod_tc : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            vld_p   <= '0;
            acc     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            vld_p <= vld_next;
            acc   <= acc_sum;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        acc   <= '0;
                        k     <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_a <= DATA_W'(sat_operand(64'(x_rd), DATA_W));
                    mul_b <= DATA_W'(sat_operand(64'(h_rd), DATA_W));
                    k     <= k + 1'b1;
                    if (int'(k) == TAPS - 1) state <= DRAIN;
                end
                DRAIN: begin
                    // Leave once only the final product (if any) remains; it is folded in via acc_sum.
                    if (vld_shift == '0) begin
                        m_valid <= 1'b1;
                        m_data  <= acc_sum;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench with a cycle-level reference model and a sign-magnitude multiplier model.
module tb_fir_mac_scheduler;

    localparam int DATA_W = 17;
    localparam int TAPS = 8;
    localparam int MUL_LATENCY = 2;
    localparam int AW = $clog2(TAPS);
    localparam int ACC_W = 2 * DATA_W - 1 + $clog2(TAPS);
    localparam int PW = 2 * DATA_W - 1;
    localparam int MW = PW - 1;
    localparam int OUT_LAT = TAPS + MUL_LATENCY + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic coef_we = 1'b0;
    logic m_ready = 1'b1;
    logic s_ready, m_valid, busy;
    logic signed [DATA_W-1:0] s_data = '0;
    logic signed [DATA_W-1:0] coef_data = '0;
    logic signed [DATA_W-1:0] mul_a, mul_b;
    logic [AW-1:0] coef_addr = '0;
    logic [PW-1:0] mul_p, mul_p_q;
    logic signed [ACC_W-1:0] m_data;
    logic force_negzero = 1'b0;

    int checks = 0;
    int passed = 0;

    // model state
    longint mx [TAPS];
    longint mh [TAPS];
    longint exp_y = 0;
    int     la = 0;
    int     cyc = 0;
    bit     pending = 0;

    fir_mac_scheduler #(
        .DATA_W     (DATA_W),
        .TAPS       (TAPS),
        .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Registered sign-magnitude multiplier: product appears one cycle after the operands.
    always @(posedge clk) begin
        longint pr;
        pr = longint'(mul_a) * longint'(mul_b);
        mul_p_q <= {pr < 0, MW'(pr < 0 ? -pr : pr)};
    end
    assign mul_p = force_negzero ? {1'b1, {MW{1'b0}}} : mul_p_q;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic longint satv(input longint v);
        return (v == -(longint'(1) <<< (DATA_W - 1))) ? v + 1 : v;
    endfunction

    // Reference model: one result per accepted sample, valid OUT_LAT cycles after the accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mx[i]) begin
                mx[i] = 0;
                mh[i] = 0;
            end
            pending = 0;
            cyc = 0;
        end else begin
            bit mv;
            bit was_pending;
            mv = pending && (cyc >= la + OUT_LAT);
            was_pending = pending;
            if (coef_we && !was_pending && int'(coef_addr) < TAPS) mh[coef_addr] = coef_data;
            if (mv && m_ready) begin
                pending = 0;
            end else if (!was_pending && s_valid) begin
                for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = s_data;
                la = cyc;
                pending = 1;
                exp_y = 0;
                for (int i = 0; i < TAPS; i++) exp_y += satv(mx[i]) * satv(mh[i]);
                if (force_negzero) exp_y = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit ev;
            ev = pending && (cyc >= la + OUT_LAT);
            check("s_ready", longint'(s_ready), longint'(!pending));
            check("busy", longint'(busy), longint'(pending));
            check("m_valid", longint'(m_valid), longint'(ev));
            if (ev) check("m_data", longint'(m_data), exp_y);
        end
    end

    task automatic wr_coef(input int a, input longint v);
        coef_we = 1'b1;
        coef_addr = AW'(a);
        coef_data = DATA_W'(v);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input longint v, output int t);
        int n;
        n = 0;
        t = 0;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data = DATA_W'(v);
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("accept_timeout", 0, 1);
        t = cyc;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_out(input longint expv, input int t, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) begin
            check("out_timeout", 0, 1);
            m_ready = 1'b1;
            return;
        end
        check("latency", cyc - t, OUT_LAT);
        check("result", longint'(m_data), expv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", longint'(m_valid), 1);
            check("hold_data", longint'(m_data), expv);
            check("hold_sready", longint'(s_ready), 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 m_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("s_ready_return", longint'(s_ready), 1);
        if (hold == 0) check("ready_latency", cyc - t, OUT_LAT + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", longint'(s_ready), 1);
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_mul_a", longint'(mul_a), 0);
        check("rst_mul_b", longint'(mul_b), 0);
        check("rst_m_data", longint'(m_data), 0);

        // Impulse response with h[k] = k+1
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 1 : 0, t);
            wait_out(i + 1, t, 0);
        end

        // Sign handling
        wr_coef(0, -3);
        for (int i = 1; i < TAPS; i++) wr_coef(i, 0);
        send(-5, t);
        wait_out(15, t, 0);
        send(5, t);
        wait_out(-15, t, 0);
        force_negzero = 1'b1;
        send(-5, t);
        wait_out(0, t, 0);
        force_negzero = 1'b0;

        // Saturation of the most negative operand
        wr_coef(0, -65536);
        send(-65536, t);
        @(negedge clk);
        @(negedge clk);
        check("sat_mul_a", longint'(mul_a), -65535);
        check("sat_mul_b", longint'(mul_b), -65535);
        wait_out(64'sd4294836225, t, 0);

        // Backpressure, with a coefficient write attempted mid-computation
        wr_coef(0, 3);
        wr_coef(1, 4);
        m_ready = 1'b0;
        send(2, t);
        wr_coef(1, 9);
        wait_out(-262134, t, 5);
        send(0, t);
        wait_out(8, t, 0);

        // Reset in the middle of ISSUE
        send(1, t);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_m_valid", longint'(m_valid), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        send(1, t);
        wait_out(0, t, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
